// File: rtl/kanagawa_apc_fifo_pkg.sv
// Shared definitions for the auto-pipeline credit FIFO.
// Holds the counter-width helper and the protocol-error codes.
package kanagawa_apc_fifo_pkg;

  // Width needed to count 0..depth inclusive.
  function automatic int unsigned clog2_plus1(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    APC_ERR_NONE,
    APC_ERR_CREDIT,
    APC_ERR_FULL_WRITE
  } apc_err_e;

endpackage

// File: rtl/auto_pipeline_credit_fifo_if.sv
// Consumer-side valid/ready stream of the auto-pipeline credit FIFO.
// master = FIFO side, slave = consumer side.
interface auto_pipeline_credit_fifo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic             ready_out;

  modport master (output valid_out, output data_out, input ready_out);
  modport slave  (input valid_out, input data_out, output ready_out);
endinterface

// File: rtl/auto_pipeline_credit_fifo_storage.sv
// Payload register array for the credit FIFO.
// Data storage carries no reset; validity is tracked by the occupancy count.
module auto_pipeline_credit_fifo_storage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the incoming chain payload into the addressed slot.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/auto_pipeline_credit_fifo.sv
// Auto-pipeline credit FIFO: absorbs the chain's enable/data output and
// presents a first-word-fall-through valid/ready stream. Issue credits count
// stored plus in-flight items so the FIFO cannot overflow for any chain depth.
// Optional statistics ports are enabled with `define KANAGAWA_APC_FIFO_STATS_EN.
module auto_pipeline_credit_fifo
  import kanagawa_apc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned MAX_LATENCY = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            issue_in,
  output logic                            can_send,
  input  logic                            pipe_enable,
  input  logic [WIDTH-1:0]                pipe_data,
  auto_pipeline_credit_fifo_if.master     out_if,
  output logic [clog2_plus1(DEPTH)-1:0]   occupancy,
  output logic                            overflow
`ifdef KANAGAWA_APC_FIFO_STATS_EN
  ,
  output logic [clog2_plus1(DEPTH)-1:0]   peak_reserved,
  output logic [31:0]                     stall_count
`endif
);

  localparam int unsigned CW = clog2_plus1(DEPTH);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 1) begin : g_depth_check
    $error("auto_pipeline_credit_fifo: DEPTH must be >= 1");
  end
  if (DEPTH < MAX_LATENCY + 2) begin : g_throughput_check
    $warning("auto_pipeline_credit_fifo: DEPTH < MAX_LATENCY+2 limits throughput");
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [CW-1:0]    reserved_q, reserved_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             take, pop, full, wr_en;
  logic [WIDTH-1:0] rd_data;

  assign can_send = (reserved_q < CW'(DEPTH));
  assign full     = (count_q == CW'(DEPTH));

  // Credit, occupancy, pointer and error-flag next-state logic.
  always_comb begin
    take       = issue_in & can_send;
    pop        = (count_q != '0) & out_if.ready_out;
    wr_en      = pipe_enable & (~full | pop);
    reserved_d = reserved_q;
    // Clamp at zero: a pop with no credit outstanding only occurs when the
    // producer failed to flush the chain across reset.
    if (take && !pop)                          reserved_d = reserved_q + 1'b1;
    else if (!take && pop && reserved_q != '0) reserved_d = reserved_q - 1'b1;
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
    wr_ptr_d   = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    overflow_d = overflow_q | (issue_in & ~can_send) | (pipe_enable & ~wr_en);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reserved_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      reserved_q <= reserved_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  auto_pipeline_credit_fifo_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr_q),
    .wr_data (pipe_data),
    .rd_ptr  (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign out_if.valid_out = (count_q != '0);
  assign out_if.data_out  = (count_q != '0) ? rd_data : '0;
  assign occupancy        = count_q;
  assign overflow         = overflow_q;

`ifdef KANAGAWA_APC_FIFO_STATS_EN
  logic [CW-1:0] peak_reserved_q, peak_reserved_d;
  logic [31:0]   stall_count_q, stall_count_d;

  // Running credit high-water mark and saturating stall-cycle counter.
  always_comb begin
    peak_reserved_d = (reserved_q > peak_reserved_q) ? reserved_q : peak_reserved_q;
    stall_count_d   = stall_count_q;
    if (!can_send && stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_reserved_q <= '0;
      stall_count_q   <= '0;
    end else begin
      peak_reserved_q <= peak_reserved_d;
      stall_count_q   <= stall_count_d;
    end
  end

  assign peak_reserved = peak_reserved_q;
  assign stall_count   = stall_count_q;
`endif

endmodule
